keypad_scanner: RTL
===================

# keypad_scanner

Sequencing controller for the Lab 3 keypad. It drives the four column lines one at a time (active-low), synchronizes the four active-low row inputs, and debounces both key press and key release. It feeds the latched column/row pair to `keypad_decoder`, and emits a registered hex code with a one-cycle `key_valid` strobe per accepted press. It sits between the keypad pins and the display/entry logic.

## Interface
- `SCAN_CYCLES`, default 4096: clock cycles each column is driven before its rows are sampled.
- `DEBOUNCE_CYCLES`, default 240000: consecutive stable cycles required to accept a press or a release (5 ms at 48 MHz).
- `clk`  in  1: system clock; all state on rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `row`  in  4: raw keypad rows, active-low, pulled up, asynchronous to `clk`.
- `col`  out  4: column drive, one-hot-low.
- `key`  out  4: last accepted key code; holds its value until the next accepted press.
- `key_valid`  out  1: one-cycle strobe when `key` updates.
- `key_held`  out  1: high from accept until release is debounced.

## Operation
- **Synchronizer:** `row` passes through a 2-flop synchronizer to `row_sync`, which resets to 4'b1111.
- **States:** SCAN, DEB_PRESS, HELD, DEB_RELEASE.
- **SCAN:**
  - Drives `col` and counts the dwell from 0 to `SCAN_CYCLES`-1.
  - On the last dwell cycle it samples `row_sync`.
  - Exactly one bit low: latch `col` into `lat_col` and `row_sync` into `lat_row`, clear the counter, go to DEB_PRESS. `col` stays frozen.
  - Zero bits low, or two or more low (ghost/multi-key): rotate `col` left (1110→1101→1011→0111→1110) and restart the dwell.
- **DEB_PRESS:**
  - While `row_sync == lat_row`, the counter increments.
  - Any mismatch: rotate `col` and return to SCAN. No strobe.
  - Counter reaches `DEBOUNCE_CYCLES`-1: next cycle `key` ← decoder(`lat_col`, `lat_row`), `key_valid`=1 for that one cycle, `key_held`=1, go to HELD.
- **HELD:**
  - `col` stays frozen.
  - Release condition: the `lat_row` bit that was low now reads high in `row_sync`. On release, clear the counter and go to DEB_RELEASE.
  - Other row bits going low are ignored. They cause no strobe and no change to `key`.
- **DEB_RELEASE:**
  - The counter increments while the latched bit reads high.
  - If the bit reads low again: return to HELD with the counter cleared and no new strobe.
  - Counter reaches `DEBOUNCE_CYCLES`-1: `key_held`=0, rotate `col`, go to SCAN.
- **Decoder use:** `keypad_decoder` is combinational on `lat_col`/`lat_row`. Its result is registered into `key` only on accept.
- **Counter:** one shared counter, `$clog2(max(SCAN_CYCLES, DEBOUNCE_CYCLES))` bits wide, cleared on every state change.

## Timing
- **Reset values** (while `reset`=0, on any clock edge):
  - state SCAN, counter 0.
  - `col`=4'b1110, `key`=4'h0, `key_valid`=0, `key_held`=0.
  - `row_sync`=4'b1111, `lat_col`=4'b1111, `lat_row`=4'b1111.
- **Reset mid-operation:** aborts any debounce or hold immediately. No strobe is issued.
- **Dwell:** the first column after reset is driven for exactly `SCAN_CYCLES` cycles. Every column change occurs on the cycle after the sample.
- **Input latency:** `row` to `row_sync` is 2 cycles.
- **Press latency:** `key_valid` rises exactly `DEBOUNCE_CYCLES`+1 cycles after the SCAN sample cycle that detected the press. `key` and `key_held` change on the same edge.
- **Release latency:** `key_held` falls `DEBOUNCE_CYCLES`+1 cycles after the first release cycle seen in HELD.
- **Strobe rule:** `key_valid` is never high on two consecutive cycles. There is at most one strobe per HELD entry.
- **Simultaneous events:** a debounce mismatch on the same cycle the counter completes counts as a mismatch.

## Structure
- **Package `keypad_pkg`:** `state_t` enum, `COL_INIT` = 4'b1110, `ROWS_IDLE` = 4'b1111.
- **Helper in the package:** function `one_low(logic [3:0])`, true when exactly one bit is 0.
- **Sub-modules:** instantiate the existing `keypad_decoder` (`col`, `row`, `s`) once on `lat_col`/`lat_row`. No other sub-modules.

## Test plan
All scenarios use `SCAN_CYCLES`=4 and `DEBOUNCE_CYCLES`=8.
1. **Reset and idle scan:** hold `reset`=0 for 3 cycles, then release with `row`=1111. `col` sequence is 1110, 1101, 1011, 0111, 1110, with 4 cycles each. `key_valid`=0 and `key`=0 throughout.
2. **Clean press of 5:** drive `row`=1101 whenever `col`=1101 and hold for 40 cycles. Expect exactly one `key_valid` pulse, with `key`=4'h5 and `key_held`=1 on the same edge, and `col` frozen at 1101. Then set `row`=1111: `key_held` falls after 9 cycles and the next `col` is 1011.
3. **Press bounce:** `row`=1011 for 3 cycles after the sample, then 1111. No `key_valid`, and scanning continues with `col` rotating.
4. **Two keys in one column:** `row`=1100 during every column. No state change, no strobe, and `key` retains its previous value.
5. **Release bounce:** in HELD on key A, toggle the latched row bit high for 3 cycles, then low for 5 cycles, then high for good. Expect no second strobe, `key_held`=1 until the final debounce completes, and `key` stays 4'hA.
6. **Reset mid-operation:** assert `reset`=0 at debounce count 5 during a press of key D. All outputs return to reset values and no strobe is seen.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad scanner.
//   state_t   - scanner FSM states
//   COL_INIT  - column drive pattern after reset (column 0 driven low)
//   ROWS_IDLE - row pattern with no key pressed (all pulled up)
//   one_low() - true when exactly one bit of a 4-bit active-low vector is 0
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] COL_INIT  = 4'b1110;
    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    function automatic logic one_low(input logic [3:0] v);
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/keypad_decoder.sv
// keypad_decoder: combinational map from an active-low column/row pair to the
// hex code printed on the 4x4 keypad.
//   col [3:0] in  - one-hot-low column drive
//   row [3:0] in  - one-hot-low row reading
//   s   [3:0] out - key code; 0 for any pair that is not one-hot-low on both
// Layout (row index down, column index across, index = position of the 0 bit):
//   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: E 0 F D
module keypad_decoder (
    input  logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] s
);

    always_comb begin
        s = 4'h0;
        case ({col, row})
            {4'b1110, 4'b1110}: s = 4'h1;
            {4'b1101, 4'b1110}: s = 4'h2;
            {4'b1011, 4'b1110}: s = 4'h3;
            {4'b0111, 4'b1110}: s = 4'hA;
            {4'b1110, 4'b1101}: s = 4'h4;
            {4'b1101, 4'b1101}: s = 4'h5;
            {4'b1011, 4'b1101}: s = 4'h6;
            {4'b0111, 4'b1101}: s = 4'hB;
            {4'b1110, 4'b1011}: s = 4'h7;
            {4'b1101, 4'b1011}: s = 4'h8;
            {4'b1011, 4'b1011}: s = 4'h9;
            {4'b0111, 4'b1011}: s = 4'hC;
            {4'b1110, 4'b0111}: s = 4'hE;
            {4'b1101, 4'b0111}: s = 4'h0;
            {4'b1011, 4'b0111}: s = 4'hF;
            {4'b0111, 4'b0111}: s = 4'hD;
            default:            s = 4'h0;
        endcase
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column scan, row synchronizer and press/release debounce for
// a 4x4 active-low keypad.
//   clk       in  - system clock, rising edge
//   reset     in  - synchronous, active-low
//   row [3:0] in  - raw rows, active-low, asynchronous to clk
//   col [3:0] out - column drive, one-hot-low
//   key [3:0] out - last accepted key code, held until the next accepted press
//   key_valid out - one-cycle strobe on the edge key updates
//   key_held  out - high from accept until the release is debounced
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4096,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    function automatic logic [3:0] rotl(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

    logic [3:0]       row_p0;
    logic [3:0]       row_sync;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       col_nx;
    logic [3:0]       lat_col, lat_col_nx;
    logic [3:0]       lat_row, lat_row_nx;
    logic [3:0]       key_nx;
    logic             key_valid_nx;
    logic             key_held_nx;
    logic [3:0]       decoded;
    logic             rel_seen;

    keypad_decoder u_decoder (
        .col (lat_col),
        .row (lat_row),
        .s   (decoded)
    );

    // The latched key's row bit reads high again; other rows are ignored.
    assign rel_seen = |(row_sync & ~lat_row);

    // Stage p0 -> sync: two-flop synchronizer on the raw rows, then FSM state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            row_p0    <= ROWS_IDLE;
            row_sync  <= ROWS_IDLE;
            state     <= SCAN;
            cnt       <= '0;
            col       <= COL_INIT;
            lat_col   <= ROWS_IDLE;
            lat_row   <= ROWS_IDLE;
            key       <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            row_p0    <= row;
            row_sync  <= row_p0;
            state     <= state_nx;
            cnt       <= cnt_nx;
            col       <= col_nx;
            lat_col   <= lat_col_nx;
            lat_row   <= lat_row_nx;
            key       <= key_nx;
            key_valid <= key_valid_nx;
            key_held  <= key_held_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        col_nx       = col;
        lat_col_nx   = lat_col;
        lat_row_nx   = lat_row;
        key_nx       = key;
        key_valid_nx = 1'b0;
        key_held_nx  = key_held;

        case (state)
            SCAN: begin
                if (cnt == SCAN_LAST) begin
                    cnt_nx = '0;
                    if (one_low(row_sync)) begin
                        lat_col_nx = col;
                        lat_row_nx = row_sync;
                        state_nx   = DEB_PRESS;
                    end else begin
                        // No key or a ghost/multi-key pattern: move on.
                        col_nx = rotl(col);
                    end
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end

            DEB_PRESS: begin
                // Mismatch wins over a completing count.
                if (row_sync != lat_row) begin
                    cnt_nx   = '0;
                    col_nx   = rotl(col);
                    state_nx = SCAN;
                end else if (cnt == DEB_LAST) begin
                    cnt_nx       = '0;
                    key_nx       = decoded;
                    key_valid_nx = 1'b1;
                    key_held_nx  = 1'b1;
                    state_nx     = HELD;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end

            HELD: begin
                if (rel_seen) begin
                    cnt_nx   = '0;
                    state_nx = DEB_RELEASE;
                end
            end

            DEB_RELEASE: begin
                if (!rel_seen) begin
                    cnt_nx   = '0;
                    state_nx = HELD;
                end else if (cnt == DEB_LAST) begin
                    cnt_nx      = '0;
                    key_held_nx = 1'b0;
                    col_nx      = rotl(col);
                    state_nx    = SCAN;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end

            default: begin
                cnt_nx   = '0;
                state_nx = SCAN;
            end
        endcase
    end

endmodule
